// File: rtl/image_pkg.sv
// image_pkg: shared constants, FSM states and helpers for the SD image loader/writer pair.
package image_pkg;
  localparam logic [31:0] IMAGE1_START = 32'h0000_0000;
  localparam logic [31:0] IMAGE2_START = 32'h0001_0000;
  localparam logic [31:0] IMAGE3_START = 32'h0002_0000;
  localparam logic [31:0] IMAGE4_START = 32'h0003_0000;
  localparam int FB_PIXELS = 76800;
  localparam int BLOCK_BYTES = 512;
  localparam int BLOCKS_PER_IMAGE = FB_PIXELS * 3 / BLOCK_BYTES;
  typedef enum logic [2:0] {IDLE, PREFETCH, LOAD, WAIT_RDY, CMD, STREAM, NEXT_BLK, FINISH} wr_state_e;
  function automatic logic [31:0] slot_base(input logic [3:0] sel);
    return sel == 4'd1 ? IMAGE2_START : sel == 4'd2 ? IMAGE3_START :
           sel == 4'd3 ? IMAGE4_START : IMAGE1_START;
  endfunction
  function automatic logic [7:0] rgb_byte(input logic [11:0] p, input logic [1:0] ph);
    logic [3:0] c;
    c = ph == 2'd0 ? p[11:8] : ph == 2'd1 ? p[7:4] : p[3:0];
    return {c, c};
  endfunction
endpackage

// File: rtl/rgb444_byte_serializer.sv
// rgb444_byte_serializer: holds one RGB444 pixel and emits its R, G, B bytes expanded to 8 bits.
module rgb444_byte_serializer
  import image_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [11:0] pixel,
  input  logic        advance,
  output logic [7:0]  data_out,
  output logic        pixel_consumed
);
  logic [11:0] pix_q, pix_d;
  logic [1:0] phase_q, phase_d;
  logic [7:0] byte_q, byte_d;
  always_comb begin
    pix_d = load ? pixel : pix_q;
    phase_d = load ? 2'd0 : !advance ? phase_q : phase_q == 2'd2 ? 2'd0 : phase_q + 2'd1;
    byte_d = (load || advance) ? rgb_byte(pix_d, phase_d) : byte_q;
    pixel_consumed = advance && !load && phase_q == 2'd2;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pix_q <= '0;
      phase_q <= '0;
      byte_q <= '0;
    end else begin
      pix_q <= pix_d;
      phase_q <= phase_d;
      byte_q <= byte_d;
    end
  assign data_out = byte_q;
endmodule

// File: rtl/image_writer_12bit.sv
// image_writer_12bit: streams the 12-bit frame buffer to SD as 24-bit RGB, 512-byte blocks.
module image_writer_12bit
  import image_pkg::*;
#(
  parameter int N_PIXELS = FB_PIXELS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  image_select,
  output logic        busy,
  output logic        done,
  output logic [16:0] fb_addr,
  input  logic [11:0] fb_data,
  output logic [31:0] sd_block_addr,
  output logic        sd_write_block,
  output logic [7:0]  sd_data_out,
  input  logic        sd_byte_req,
  input  logic        sd_ready
);
  localparam int LAST_BLK = N_PIXELS * 3 / BLOCK_BYTES - 1;
  localparam logic [16:0] LAST_PIX = 17'(N_PIXELS - 1);
  wr_state_e state_q, state_d;
  logic [31:0] base_q, base_d, addr_q, addr_d;
  logic [16:0] pix_q, pix_d;
  logic [8:0] blk_q, blk_d, byte_cnt_q, byte_cnt_d;
  logic busy_q, busy_d, done_q, done_d, wb_q, wb_d, load_pend_q, load_pend_d;
  logic adv, consumed;
  assign adv = state_q == STREAM && sd_byte_req;
  rgb444_byte_serializer u_ser (
    .clk(clk), .rst_n(reset), .load(state_q == LOAD || load_pend_q), .pixel(fb_data),
    .advance(adv), .data_out(sd_data_out), .pixel_consumed(consumed)
  );
  always_comb begin
    state_d = state_q;
    base_d = base_q;
    pix_d = pix_q;
    blk_d = blk_q;
    byte_cnt_d = byte_cnt_q;
    busy_d = busy_q;
    addr_d = addr_q;
    done_d = 1'b0;
    wb_d = 1'b0;
    load_pend_d = consumed;
    case (state_q)
      IDLE: if (start) begin
        base_d = slot_base(image_select);
        pix_d = '0;
        blk_d = '0;
        busy_d = 1'b1;
        state_d = PREFETCH;
      end
      PREFETCH: state_d = LOAD;
      LOAD: state_d = WAIT_RDY;
      WAIT_RDY: if (sd_ready) begin
        wb_d = 1'b1;
        addr_d = base_q + 32'(blk_q);
        state_d = CMD;
      end
      CMD: begin
        byte_cnt_d = '0;
        state_d = STREAM;
      end
      // fb_addr follows pix_d so the next pixel's read is issued on the same request that consumed B
      STREAM: if (sd_byte_req) begin
        byte_cnt_d = byte_cnt_q + 9'd1;
        pix_d = (consumed && pix_q != LAST_PIX) ? pix_q + 17'd1 : pix_q;
        state_d = &byte_cnt_q ? NEXT_BLK : STREAM;
      end
      NEXT_BLK: begin
        state_d = blk_q == 9'(LAST_BLK) ? FINISH : WAIT_RDY;
        blk_d = blk_q == 9'(LAST_BLK) ? blk_q : blk_q + 9'd1;
      end
      FINISH: if (sd_ready) begin
        done_d = 1'b1;
        busy_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      base_q <= IMAGE1_START;
      addr_q <= IMAGE1_START;
      pix_q <= '0;
      blk_q <= '0;
      byte_cnt_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      wb_q <= 1'b0;
      load_pend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q <= base_d;
      addr_q <= addr_d;
      pix_q <= pix_d;
      blk_q <= blk_d;
      byte_cnt_q <= byte_cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
      wb_q <= wb_d;
      load_pend_q <= load_pend_d;
    end
  assign fb_addr = pix_d;
  assign busy = busy_q;
  assign done = done_q;
  assign sd_write_block = wb_q;
  assign sd_block_addr = addr_q;
endmodule

// File: tb/tb_image_writer_12bit.sv
// tb_image_writer_12bit: scoreboard bench with a frame-buffer model and SD block-write controller model.
module tb_image_writer_12bit;
  localparam int NPIX = 1536;
  localparam int NBLK = NPIX * 3 / 512;
  localparam int NBYTES = NPIX * 3;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, sd_byte_req = 1'b0, sd_ready = 1'b1;
  logic [3:0] image_select = 4'd0;
  logic busy, done, sd_write_block;
  logic [16:0] fb_addr;
  logic [11:0] fb_data;
  logic [31:0] sd_block_addr;
  logic [7:0] sd_data_out;
  bit pat = 1'b0;
  int total = 0, bad = 0, wb_cnt = 0, done_cnt = 0;
  logic [7:0] byte_sb[$];
  logic [31:0] addr_sb[$];
  logic [7:0] cap_first[9];
  logic [7:0] cap_bnd[4];
  typedef struct {logic [3:0] sel; logic [31:0] base;} slot_t;
  slot_t slots[6];
  logic [7:0] first_exp[9];
  logic [7:0] bnd_exp[4];

  image_writer_12bit #(.N_PIXELS(NPIX)) dut (
    .clk(clk), .reset(rst_n), .start(start), .image_select(image_select), .busy(busy),
    .done(done), .fb_addr(fb_addr), .fb_data(fb_data), .sd_block_addr(sd_block_addr),
    .sd_write_block(sd_write_block), .sd_data_out(sd_data_out), .sd_byte_req(sd_byte_req),
    .sd_ready(sd_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) fb_data <= pat ? 12'(32'(fb_addr) * 37 + 5) : fb_addr[11:0];
  always @(posedge clk) begin
    if (sd_write_block) wb_cnt++;
    if (done) done_cnt++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int k);
    logic [11:0] p = pat ? 12'((k / 3) * 37 + 5) : 12'(k / 3);
    logic [3:0] c = (k % 3 == 0) ? p[11:8] : (k % 3 == 1) ? p[7:4] : p[3:0];
    return 8'(c) * 8'h11;
  endfunction

  task automatic pulse_start(input logic [3:0] sel);
    @(negedge clk);
    image_select = sel;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_wb(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (sd_write_block) ok = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_wb"}, sd_write_block, 0);
    check({tag, "_fb_addr"}, fb_addr, 0);
    check({tag, "_data"}, sd_data_out, 0);
    check({tag, "_blk_addr"}, sd_block_addr, 32'h0);
  endtask

  task automatic run_frame(input logic [3:0] sel, input logic [31:0] base, input int abort_blk,
                           input int stall_blk, input bit noise);
    bit ok;
    int k = 0;
    int d0 = done_cnt;
    int w0 = wb_cnt;
    for (int b = 0; b < NBLK; b++) addr_sb.push_back(base + 32'(b));
    for (int i = 0; i < NBYTES; i++) byte_sb.push_back(exp_byte(i));
    pulse_start(sel);
    check("busy_after_start", busy, 1);
    for (int b = 0; b < NBLK; b++) begin
      if (b == stall_blk) begin
        int seen = 0;
        repeat (100) begin
          @(negedge clk);
          if (sd_write_block) seen++;
        end
        check("stall_no_cmd", seen, 0);
        sd_ready = 1'b1;
      end
      wait_wb(ok);
      check("cmd_seen", ok, 1);
      if (!ok) return;
      check($sformatf("blk_addr%0d", b), sd_block_addr, addr_sb.pop_front());
      sd_ready = 1'b0;
      if (noise) image_select = 4'($urandom);
      for (int i = 0; i < 512; i++) begin
        if (b == abort_blk && i == 100) begin
          rst_n = 1'b0;
          @(negedge clk);
          check_reset_vals("abort");
          byte_sb.delete();
          addr_sb.delete();
          rst_n = 1'b1;
          sd_ready = 1'b1;
          repeat (50) @(negedge clk);
          check("abort_no_done", done_cnt - d0, 0);
          check("abort_no_cmd", wb_cnt - w0, b + 1);
          return;
        end
        @(negedge clk);
        sd_byte_req = 1'b1;
        if (k < 9) cap_first[k] = sd_data_out;
        if (k >= 510 && k <= 513) cap_bnd[k - 510] = sd_data_out;
        check($sformatf("byte%0d", k), sd_data_out, byte_sb.pop_front());
        k++;
        @(negedge clk);
        sd_byte_req = 1'b0;
        start = noise && b == 2 && i == 5;
        repeat (3) begin
          @(negedge clk);
          start = 1'b0;
        end
      end
      check($sformatf("blk_addr_hold%0d", b), sd_block_addr, base + 32'(b));
      sd_ready = (b + 1 != stall_blk);
    end
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        check("busy_at_done", busy, 0);
      end
    end
    check("done_seen", ok, 1);
    repeat (20) @(negedge clk);
    check("done_once", done_cnt - d0, 1);
    check("cmd_count", wb_cnt - w0, NBLK);
    check("sb_empty", byte_sb.size() + addr_sb.size(), 0);
    check("busy_idle", busy, 0);
  endtask

  initial begin
    bit ok;
    slots = '{'{4'd0, 32'h0000_0000}, '{4'd1, 32'h0001_0000}, '{4'd2, 32'h0002_0000},
              '{4'd3, 32'h0003_0000}, '{4'd4, 32'h0000_0000}, '{4'hF, 32'h0000_0000}};
    first_exp = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h11, 8'h00, 8'h00, 8'h22};
    bnd_exp = '{8'h00, 8'hAA, 8'hAA, 8'h00};
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);
    for (int s = 0; s < 6; s++) begin
      pulse_start(slots[s].sel);
      wait_wb(ok);
      check($sformatf("slot_cmd%0d", s), ok, 1);
      check($sformatf("slot_base%0d", s), sd_block_addr, slots[s].base);
      rst_n = 1'b0;
      @(negedge clk);
      check($sformatf("slot_abort_busy%0d", s), busy, 0);
      rst_n = 1'b1;
      @(negedge clk);
    end
    run_frame(4'd2, 32'h0002_0000, 3, -1, 1'b0);
    run_frame(4'd2, 32'h0002_0000, -1, -1, 1'b0);
    for (int i = 0; i < 9; i++) check($sformatf("first_byte%0d", i), cap_first[i], first_exp[i]);
    for (int i = 0; i < 4; i++) check($sformatf("bnd_byte%0d", 510 + i), cap_bnd[i], bnd_exp[i]);
    pat = 1'b1;
    run_frame(4'hF, 32'h0000_0000, -1, 7, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/image_writer_12bit.md
Name: image_writer_12bit

Overview:
Streams the 320x240 12-bit frame buffer back to SD card as 24-bit RGB. This is the write-direction counterpart of the SD-to-frame-buffer image loader.
- Reads pixels through a synchronous frame-buffer read port.
- Expands RGB444 to RGB888 and serializes 3 bytes per pixel.
- Drives an SD block-write controller, 512 bytes per block.
- Triggered by a start pulse; sits alongside the loader on the same SD controller and frame buffer.

Parameters:
- IMAGE1_START, 32'h00000000, SD block base of slot 0
- IMAGE2_START, 32'h00010000, SD block base of slot 1
- IMAGE3_START, 32'h00020000, SD block base of slot 2
- IMAGE4_START, 32'h00030000, SD block base of slot 3
- FB_PIXELS, 76800, pixels per image
- BLOCK_BYTES, 512, bytes per SD block

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  single-cycle request to save the frame buffer
- image_select  in  4  slot; 0..3 select IMAGE1..4_START, other values select IMAGE1_START
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after the last block completes
- fb_addr  out  17  frame-buffer read address
- fb_data  in  12  pixel {R[3:0],G[3:0],B[3:0]}, valid 1 cycle after fb_addr
- sd_block_addr  out  32  block being written; stable from sd_write_block until that block's 512th byte is consumed
- sd_write_block  out  1  one-cycle write command pulse
- sd_data_out  out  8  current byte; must be valid whenever sd_byte_req is high
- sd_byte_req  in  1  controller consumed sd_data_out; pulses are at least 4 cycles apart
- sd_ready  in  1  controller idle and able to accept a command

Behaviour:
- Reset (reset=0, async) values: busy=0, done=0, sd_write_block=0, fb_addr=0, sd_data_out=0, sd_block_addr=IMAGE1_START; FSM goes to IDLE.
- Reset mid-transfer aborts immediately; no done pulse is issued.
- Colour expansion: each 4-bit channel c becomes the byte {c,c}, e.g. 4'hA -> 8'hAA.
- Byte order per pixel: R, G, B.
- The byte stream is continuous across block boundaries; pixels may straddle blocks (512 is not a multiple of 3).
- Totals: 230400 bytes = exactly 450 blocks, numbered base+0 .. base+449.
- FSM states:
  - IDLE: on start, latch base from image_select, set pix=0, blk=0, busy=1 -> PREFETCH. start is ignored while busy.
  - PREFETCH: drive fb_addr=pix, wait 1 cycle, latch fb_data into the pixel register, set phase=0, present the R byte -> WAIT_RDY.
  - WAIT_RDY: wait for sd_ready=1 -> CMD.
  - CMD: sd_block_addr=base+blk, pulse sd_write_block for 1 cycle, clear byte_cnt -> STREAM.
  - STREAM: on each sd_byte_req, increment byte_cnt (9-bit) and advance phase R->G->B.
    - On the request that consumes B: increment pix, issue the fb read, and present the next R byte within 2 cycles (before the next request).
    - On the request that consumes byte 511 -> NEXT_BLK.
  - NEXT_BLK: if blk==449 -> FINISH; else increment blk -> WAIT_RDY.
  - FINISH: wait for sd_ready=1, pulse done for 1 cycle, clear busy -> IDLE.
- sd_byte_req outside STREAM is ignored.
- Changing image_select while busy has no effect; the base is latched at start.
- pix saturates at 76799. Its last B byte coincides with byte 511 of block 449, so no padding is needed.
- No combinational path from sd_byte_req to sd_data_out; sd_data_out is registered.

Decomposition:
- Shared package image_pkg holds:
  - IMAGE*_START, FB_PIXELS, BLOCK_BYTES, BLOCKS_PER_IMAGE=450
  - FSM state enum
  - the slot-to-base mapping function, shared with the loader
- One sub-module, rgb444_byte_serializer: holds the pixel register and phase counter, and outputs the expanded byte plus a pixel_consumed strobe.

Test Plan:
- Reset while busy mid-block 3 -> all outputs return to reset values; done never pulses; a later start restarts at block base+0, pixel 0.
- Frame buffer pixel n = n[11:0], start with image_select=2, controller asserting sd_byte_req every 8 cycles -> sd_write_block pulses 450 times at addresses 32'h00020000..32'h000201C1. The first bytes are 00,00,00,00,00,11,00,00,22. done pulses once; busy low after done.
- Block boundary: capture bytes 510..513 -> pixel 170 is split, with R,G in block 0 and B as byte 0 of block 1; values are unchanged.
- image_select=4'hF -> base is 32'h00000000. Toggling image_select mid-transfer leaves sd_block_addr unchanged.
- sd_ready held low for 100 cycles before block 7 -> no sd_write_block until sd_ready rises; byte stream continues without loss or duplication.
- Second start pulse while busy -> ignored; exactly 450 blocks are written and done pulses once.
